// File: rtl/mmm_controller_if.sv
// Purpose: start/busy/done handshake and memory-port bundle between the
//          matrix-multiply sequencer and the partitioned data memory.
// Ports (signals):
//   start, busy, done            processor handshake
//   mem1_rd_addr / mem1_rd_data  matrix A read port (data one cycle after address)
//   mem2_rd_addr / mem2_rd_data  matrix B read port (data one cycle after address)
//   mem3_wr_addr / mem3_wr_data / mem3_byte_wren  matrix C write port
// Modports: master = sequencer side, slave = processor/memory side.
interface mmm_controller_if #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned QUARTER_BITS = 6
);
   logic                    start;
   logic                    busy;
   logic                    done;
   logic [QUARTER_BITS-1:0] mem1_rd_addr;
   logic [QUARTER_BITS-1:0] mem2_rd_addr;
   logic [WIDTH-1:0]        mem1_rd_data;
   logic [WIDTH-1:0]        mem2_rd_data;
   logic [QUARTER_BITS-1:0] mem3_wr_addr;
   logic [WIDTH-1:0]        mem3_wr_data;
   logic [3:0]              mem3_byte_wren;

   modport master (
      input  start, mem1_rd_data, mem2_rd_data,
      output busy, done, mem1_rd_addr, mem2_rd_addr,
             mem3_wr_addr, mem3_wr_data, mem3_byte_wren
   );

   modport slave (
      output start, mem1_rd_data, mem2_rd_data,
      input  busy, done, mem1_rd_addr, mem2_rd_addr,
             mem3_wr_addr, mem3_wr_data, mem3_byte_wren
   );
endinterface

// File: rtl/mmm_controller.sv
// Purpose: sequencer computing C = A x B (DIM x DIM, row-major, base 0) with one
//          multiply-accumulate per cycle; A from memory 1, B from memory 2,
//          C written to memory 3. Processor launches with start, polls busy/done.
// Ports:
//   clk          single clock, posedge
//   reset        synchronous active-low reset
//   bus          mmm_controller_if.master (handshake + memory ports)
//   cycle_count  busy-cycle counter, present only with MMM_PERF_CNT_EN defined
// Optional feature macro: MMM_PERF_CNT_EN
module mmm_controller #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned SIZE         = 256,
   parameter int unsigned QUARTER_BITS = $clog2(SIZE) - 2,
   parameter int unsigned DIM          = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   mmm_controller_if.master       bus
`ifdef MMM_PERF_CNT_EN
   ,
   output logic [31:0]            cycle_count
`endif
);

   localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

   // Matrix must fit in one quarter memory.
   if (DIM * DIM > SIZE / 4) begin : g_dim_check
      $error("mmm_controller: DIM*DIM exceeds SIZE/4");
   end

   typedef enum logic [2:0] {IDLE, LOAD, LAST, WRITE, DONE} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
   logic [WIDTH-1:0]        acc_q, acc_d;
   logic [QUARTER_BITS-1:0] rd1_q, rd1_d, rd2_q, rd2_d, wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]        wr_data_q, wr_data_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic [3:0]              wren_q, wren_d;
   logic [WIDTH-1:0]        prod;

   // Low WIDTH bits of a two's-complement product do not depend on signedness.
   assign prod = bus.mem1_rd_data * bus.mem2_rd_data;

   // Row-major linear address of element (r, c).
   function automatic logic [QUARTER_BITS-1:0] lin(input logic [IDX_W-1:0] r,
                                                   input logic [IDX_W-1:0] c);
      return QUARTER_BITS'(r) * QUARTER_BITS'(DIM) + QUARTER_BITS'(c);
   endfunction

   // State and output registers; outputs are loaded with next-state values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wren_q    <= 4'b0000;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wren_q    <= wren_d;
      end
   end

   // Next-state, index/accumulator update and next output values.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      acc_d     = acc_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      case (state_q)
         IDLE: begin
            rd1_d = '0;
            rd2_d = '0;
            if (bus.start) begin
               state_d = LOAD;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               acc_d   = '0;
            end
         end
         LOAD: begin
            // Read data in this cycle belongs to the previous k.
            if (k_q != '0) acc_d = acc_q + prod;
            if (k_q == IDX_LAST) begin
               state_d = LAST;
            end else begin
               k_d   = k_q + IDX_W'(1);
               rd1_d = lin(i_q, k_d);
               rd2_d = lin(k_d, j_q);
            end
         end
         LAST: begin
            acc_d     = acc_q + prod;
            state_d   = WRITE;
            wr_addr_d = lin(i_q, j_q);
            wr_data_d = acc_d;
         end
         WRITE: begin
            if (i_q == IDX_LAST && j_q == IDX_LAST) begin
               state_d = DONE;
            end else begin
               if (j_q == IDX_LAST) begin
                  j_d = '0;
                  i_d = i_q + IDX_W'(1);
               end else begin
                  j_d = j_q + IDX_W'(1);
               end
               k_d     = '0;
               acc_d   = '0;
               rd1_d   = lin(i_d, '0);
               rd2_d   = lin('0, j_d);
               state_d = LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
            rd1_d   = '0;
            rd2_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == LOAD) || (state_d == LAST) || (state_d == WRITE);
      done_d = (state_d == DONE);
      wren_d = (state_d == WRITE) ? 4'b1111 : 4'b0000;
   end

`ifdef MMM_PERF_CNT_EN
   // Busy-cycle counter: zeroed when a start is accepted, frozen outside busy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_count <= '0;
      end else if (state_q == IDLE && bus.start) begin
         cycle_count <= '0;
      end else if (busy_q) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.mem1_rd_addr   = rd1_q;
   assign bus.mem2_rd_addr   = rd2_q;
   assign bus.mem3_wr_addr   = wr_addr_q;
   assign bus.mem3_wr_data   = wr_data_q;
   assign bus.mem3_byte_wren = wren_q;

endmodule

// File: tb/tb_mmm_controller.sv
// Bench for mmm_controller at DIM=4, WIDTH=32, SIZE=256.
module tb_mmm_controller;
   localparam int unsigned N  = 4;
   localparam int unsigned QB = 6;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mmm_controller_if #(.WIDTH(32), .QUARTER_BITS(QB)) bus ();
`ifdef MMM_PERF_CNT_EN
   logic [31:0] cycle_count;
`endif

   mmm_controller #(.WIDTH(32), .SIZE(256), .QUARTER_BITS(QB), .DIM(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
`ifdef MMM_PERF_CNT_EN
      ,
      .cycle_count (cycle_count)
`endif
   );

   logic [31:0] mem1 [64];
   logic [31:0] mem2 [64];
   logic [31:0] exp_c [16];

   // Synchronous-read memory model: data one cycle after address.
   always @(posedge clk) begin
      bus.mem1_rd_data <= mem1[bus.mem1_rd_addr];
      bus.mem2_rd_data <= mem2[bus.mem2_rd_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      bit          a_ident;
      logic [31:0] a_val;
      bit          b_ramp;
      logic [31:0] b_val;
      bit          c_ramp;
      logic [31:0] c_val;
      bit          hold_start;
   } vec_t;

   vec_t vecs [6];

   task automatic load_mats(input vec_t v);
      for (int r = 0; r < 64; r++) begin
         mem1[r] = 32'h0;
         mem2[r] = 32'h0;
      end
      for (int r = 0; r < int'(N); r++) begin
         for (int c = 0; c < int'(N); c++) begin
            mem1[r*N+c] = v.a_ident ? ((r == c) ? 32'd1 : 32'd0) : v.a_val;
            mem2[r*N+c] = v.b_ramp ? 32'(r*N + c + 1) : v.b_val;
            exp_c[r*N+c] = v.c_ramp ? 32'(r*N + c + 1) : v.c_val;
         end
      end
   endtask

   // One full computation, sampled on negedges; bounded at 110 cycles.
   task automatic run_one(input string tag, input bit hold);
      int busy_cnt = 0;
      int done_cnt = 0;
      int wr_cnt   = 0;
      int last_busy = -1;
      int done_cyc  = -1;
      @(negedge clk);
      bus.start = 1'b1;
      for (int cyc = 0; cyc < 110; cyc++) begin
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         if (done_cyc >= 0 && cyc == done_cyc + 1) bus.start = 1'b0;
         if (bus.busy === 1'b1) begin
            busy_cnt++;
            last_busy = cyc;
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.mem3_byte_wren === 4'hF) begin
            if (wr_cnt < 16) begin
               check($sformatf("%s wr_addr[%0d]", tag, wr_cnt), 32'(bus.mem3_wr_addr), 32'(wr_cnt));
               check($sformatf("%s wr_data[%0d]", tag, wr_cnt), bus.mem3_wr_data, exp_c[wr_cnt]);
            end
            wr_cnt++;
         end else if (bus.mem3_byte_wren !== 4'h0) begin
            check($sformatf("%s wren_value", tag), 32'(bus.mem3_byte_wren), 32'h0);
         end
      end
      bus.start = 1'b0;
      check($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'd96);
      check($sformatf("%s write_count", tag), 32'(wr_cnt), 32'd16);
      check($sformatf("%s done_pulses", tag), 32'(done_cnt), 32'd1);
      check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'd96);
      check($sformatf("%s done_after_busy", tag), 32'(done_cyc), 32'(last_busy + 1));
`ifdef MMM_PERF_CNT_EN
      check($sformatf("%s cycle_count", tag), cycle_count, 32'd96);
      repeat (3) @(negedge clk);
      check($sformatf("%s cycle_count_hold", tag), cycle_count, 32'd96);
`endif
   endtask

   initial begin
      bus.start = 1'b1;
      vecs[0] = '{"identity",  1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b0};
      vecs[1] = '{"neg_one",   1'b0, 32'hFFFFFFFF, 1'b0, 32'h2,        1'b0, 32'hFFFFFFF8, 1'b0};
      vecs[2] = '{"wrap_zero", 1'b0, 32'h00010000, 1'b0, 32'h00010000, 1'b0, 32'h00000000, 1'b0};
      vecs[3] = '{"small",     1'b0, 32'd3,        1'b0, 32'd5,        1'b0, 32'd60,       1'b0};
      vecs[4] = '{"max_pos",   1'b0, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0, 32'h00000004, 1'b0};
      vecs[5] = '{"held_start",1'b1, 32'h0,        1'b0, 32'h80000000, 1'b0, 32'h80000000, 1'b1};

      // Reset held with start asserted.
      repeat (3) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset done", 32'(bus.done), 32'h0);
      check("reset wren", 32'(bus.mem3_byte_wren), 32'h0);
      check("reset rd1", 32'(bus.mem1_rd_addr), 32'h0);
      check("reset rd2", 32'(bus.mem2_rd_addr), 32'h0);
      check("reset wr_addr", 32'(bus.mem3_wr_addr), 32'h0);
      check("reset wr_data", bus.mem3_wr_data, 32'h0);
`ifdef MMM_PERF_CNT_EN
      check("reset cycle_count", cycle_count, 32'h0);
`endif
      bus.start = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[v]) begin
         load_mats(vecs[v]);
         run_one(vecs[v].name, vecs[v].hold_start);
      end

      // Reset dropped at busy cycle 30.
      begin
         int busy_cnt = 0;
         bit hit = 1'b0;
         load_mats(vecs[0]);
         @(negedge clk);
         bus.start = 1'b1;
         for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (busy_cnt == 30) begin
               hit = 1'b1;
               reset = 1'b0;
               @(negedge clk);
               check("abort busy", 32'(bus.busy), 32'h0);
               check("abort wren", 32'(bus.mem3_byte_wren), 32'h0);
               check("abort done", 32'(bus.done), 32'h0);
               check("abort rd1", 32'(bus.mem1_rd_addr), 32'h0);
               check("abort wr_addr", 32'(bus.mem3_wr_addr), 32'h0);
            end
         end
         check("abort reached", 32'(hit), 32'h1);
         reset = 1'b1;
         @(negedge clk);
         run_one("after_reset", 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
